// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU "A", loader/debug "B") arbiter in front of a
// single-ported synchronous data memory. One access in flight at a time,
// three-state FSM IDLE -> ISSUE -> RESP.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_req/a_wren/a_addr/a_wdata   CPU request port (held until a_gnt)
//   b_req/b_wren/b_addr/b_wdata   loader/debug request port (held until b_gnt)
//   a_gnt, b_gnt             one-cycle grant pulse (ISSUE cycle)
//   a_rvalid, b_rvalid       one-cycle completion pulse (cycle after RESP)
//   rdata                    read data, valid while an rvalid is high
//   mem_address/mem_data/mem_wren   memory drive, mem_q memory read data
//   busy                     high whenever the FSM is not IDLE
//
// Latency: req sampled in IDLE at T -> gnt T+1 -> rvalid/rdata T+3.
// Configuration: define DMEM_ARBITER_RR_EN for round-robin tie breaking;
// otherwise port A wins every tie (fixed priority, no pointer register).

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_wren,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_wren,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic                  hold_wren_q, hold_wren_d;
  logic                  hold_id_q, hold_id_d;     // 0 = port A, 1 = port B
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  win_b;

`ifdef DMEM_ARBITER_RR_EN
  // Last port served: 1 = B. Reset value makes A win the first tie.
  logic last_b_q, last_b_d;

  always_comb begin
    win_b = b_req & (~a_req | ~last_b_q);
  end
`else
  always_comb begin
    win_b = b_req & ~a_req;
  end
`endif

  always_comb begin
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_wren_d  = hold_wren_q;
    hold_id_d    = hold_id_q;
    rdata_d      = rdata_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
`ifdef DMEM_ARBITER_RR_EN
    last_b_d     = last_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          hold_id_d    = win_b;
          hold_addr_d  = win_b ? b_addr  : a_addr;
          hold_wdata_d = win_b ? b_wdata : a_wdata;
          hold_wren_d  = win_b ? b_wren  : a_wren;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
`ifdef DMEM_ARBITER_RR_EN
        last_b_d = hold_id_q;
`endif
        state_d = RESP;
      end
      RESP: begin
        // Writes leave rdata untouched; mem_q is only meaningful for reads.
        if (!hold_wren_q) begin
          rdata_d = mem_q;
        end
        a_rvalid_d = ~hold_id_q;
        b_rvalid_d = hold_id_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_wren_q  <= 1'b0;
      hold_id_q    <= 1'b0;
      rdata_q      <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
`ifdef DMEM_ARBITER_RR_EN
      last_b_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wren_q  <= hold_wren_d;
      hold_id_q    <= hold_id_d;
      rdata_q      <= rdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
`ifdef DMEM_ARBITER_RR_EN
      last_b_q     <= last_b_d;
`endif
    end
  end

  // Decoded straight from state so reset drops them without waiting for clk.
  assign a_gnt       = (state_q == ISSUE) & ~hold_id_q;
  assign b_gnt       = (state_q == ISSUE) &  hold_id_q;
  assign mem_wren    = (state_q == ISSUE) &  hold_wren_q;
  assign busy        = (state_q != IDLE);
  assign mem_address = hold_addr_q;
  assign mem_data    = hold_wdata_q;
  assign rdata       = rdata_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and random traffic on both ports, checked
// against a transaction-level model (serial accesses, fixed 3-cycle slot,
// tie-break rule, reference memory image).
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_wren, b_req, b_wren;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wren, busy;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_address;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy)
  );

  // Synchronous memory: q valid one cycle after the address edge.
  logic [DW-1:0] ram [0:63];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address[5:0]] <= mem_data;
    mem_q <= ram[mem_address[5:0]];
  end

  typedef struct packed {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  // Reference model state
  logic [DW-1:0] ref_mem [0:63];
  acc_t          qa[$], qb[$];
  acc_t          cur_a, cur_b;
  bit            pa, pb;
  int            cyc, free_cyc;
  bit            last_b;
  logic [DW-1:0] exp_rdata;
  bit            e_agnt [0:NCYC-1];
  bit            e_bgnt [0:NCYC-1];
  bit            e_arv  [0:NCYC-1];
  bit            e_brv  [0:NCYC-1];
  bit            e_wren [0:NCYC-1];
  bit            e_busy [0:NCYC-1];
  bit            e_iss  [0:NCYC-1];
  logic [AW-1:0] e_addr [0:NCYC-1];
  logic [DW-1:0] e_data [0:NCYC-1];
  bit            upd_v  [0:NCYC-1];
  logic [DW-1:0] upd_d  [0:NCYC-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic acc_t mk_acc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t r;
    r.wren  = w;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  function automatic acc_t rand_acc();
    return mk_acc(1'($urandom_range(1)), 32'($urandom_range(63)), $urandom);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCYC; i++) begin
      e_agnt[i] = 0; e_bgnt[i] = 0; e_arv[i] = 0; e_brv[i] = 0;
      e_wren[i] = 0; e_busy[i] = 0; e_iss[i] = 0; upd_v[i] = 0;
      e_addr[i] = '0; e_data[i] = '0; upd_d[i] = '0;
    end
    free_cyc  = cyc;
    last_b    = 1'b1;
    exp_rdata = '0;
    pa = 0; pb = 0;
    qa.delete(); qb.delete();
  endtask

  task automatic run(input int n, input bit rnd);
    bit   win_b;
    acc_t acc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      // Outputs of this cycle
      if (upd_v[cyc]) exp_rdata = upd_d[cyc];
      check_val("a_gnt",    {31'd0, a_gnt},    {31'd0, e_agnt[cyc]});
      check_val("b_gnt",    {31'd0, b_gnt},    {31'd0, e_bgnt[cyc]});
      check_val("a_rvalid", {31'd0, a_rvalid}, {31'd0, e_arv[cyc]});
      check_val("b_rvalid", {31'd0, b_rvalid}, {31'd0, e_brv[cyc]});
      check_val("mem_wren", {31'd0, mem_wren}, {31'd0, e_wren[cyc]});
      check_val("busy",     {31'd0, busy},     {31'd0, e_busy[cyc]});
      check_val("rdata",    rdata,             exp_rdata);
      if (e_iss[cyc]) begin
        check_val("mem_address", mem_address, e_addr[cyc]);
        if (e_wren[cyc]) check_val("mem_data", mem_data, e_data[cyc]);
      end
      // Requesters: hold until granted, then move to the next queued access
      if (e_agnt[cyc]) pa = 0;
      if (e_bgnt[cyc]) pb = 0;
      if (rnd) begin
        if (qa.size() < 2 && $urandom_range(3) == 0) qa.push_back(rand_acc());
        if (qb.size() < 2 && $urandom_range(3) == 0) qb.push_back(rand_acc());
      end
      if (!pa && qa.size() > 0) begin cur_a = qa.pop_front(); pa = 1; end
      if (!pb && qb.size() > 0) begin cur_b = qb.pop_front(); pb = 1; end
      a_req   = pa;
      a_wren  = pa ? cur_a.wren  : 1'($urandom_range(1));
      a_addr  = pa ? cur_a.addr  : $urandom;
      a_wdata = pa ? cur_a.wdata : $urandom;
      b_req   = pb;
      b_wren  = pb ? cur_b.wren  : 1'($urandom_range(1));
      b_addr  = pb ? cur_b.addr  : $urandom;
      b_wdata = pb ? cur_b.wdata : $urandom;
      // Transaction model: one access per 3-cycle slot
      if (cyc >= free_cyc && (pa || pb) && cyc + 3 < NCYC) begin
`ifdef DMEM_ARBITER_RR_EN
        win_b = pb && (!pa || !last_b);
`else
        win_b = pb && !pa;
`endif
        acc = win_b ? cur_b : cur_a;
        e_agnt[cyc+1] = !win_b;
        e_bgnt[cyc+1] = win_b;
        e_iss[cyc+1]  = 1;
        e_wren[cyc+1] = acc.wren;
        e_addr[cyc+1] = acc.addr;
        e_data[cyc+1] = acc.wdata;
        e_busy[cyc+1] = 1;
        e_busy[cyc+2] = 1;
        e_arv[cyc+3]  = !win_b;
        e_brv[cyc+3]  = win_b;
        if (acc.wren) ref_mem[acc.addr[5:0]] = acc.wdata;
        else begin
          upd_v[cyc+3] = 1;
          upd_d[cyc+3] = ref_mem[acc.addr[5:0]];
        end
        free_cyc = cyc + 3;
        last_b   = win_b;
      end
      cyc++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]     = 32'hD00D0000 + 32'(i);
      ref_mem[i] = 32'hD00D0000 + 32'(i);
    end
    ram[16]     = 32'hCAFE0001;
    ref_mem[16] = 32'hCAFE0001;
    rst = 1'b1;
    a_req = 0; a_wren = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wren = 0; b_addr = '0; b_wdata = '0;
    cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_gnt",    {30'd0, a_gnt, b_gnt},       32'd0);
    check_val("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check_val("rst_wren_busy", {30'd0, mem_wren, busy},  32'd0);
    check_val("rst_rdata",  rdata,       32'd0);
    check_val("rst_addr",   mem_address, 32'd0);
    check_val("rst_data",   mem_data,    32'd0);
    model_reset();
    rst = 1'b0;

    // Single read of a preloaded word
    qa.push_back(mk_acc(1'b0, 32'h10, 32'h0));
    run(6, 0);
    // Port B write then read back
    qb.push_back(mk_acc(1'b1, 32'h20, 32'h12345678));
    qb.push_back(mk_acc(1'b0, 32'h20, 32'h0));
    run(10, 0);
    // Both ports held high: tie-break sequence
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mk_acc(1'b0, 32'(i), 32'h0));
      qb.push_back(mk_acc(1'b0, 32'(i + 8), 32'h0));
    end
    run(22, 0);
    // Back-to-back on A with no idle gap
    for (int i = 0; i < 3; i++) qa.push_back(mk_acc(1'(i % 2), 32'(40 + i), $urandom));
    run(12, 0);
    // Random traffic
    run(1500, 1);
    run(30, 0);

    // Reset during ISSUE of an A write
    @(negedge clk);
    a_req = 1; a_wren = 1; a_addr = 32'd5; a_wdata = 32'hDEADBEEF;
    b_req = 0;
    @(negedge clk);
    check_val("mid_a_gnt",    {31'd0, a_gnt},    32'd1);
    check_val("mid_mem_wren", {31'd0, mem_wren}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("rst_mid_wren", {31'd0, mem_wren}, 32'd0);
    check_val("rst_mid_busy", {31'd0, busy},     32'd0);
    check_val("rst_mid_gnt",  {31'd0, a_gnt},    32'd0);
    a_req = 0;
    repeat (2) @(negedge clk);
    check_val("rst_mid_rvalid", {31'd0, a_rvalid}, 32'd0);
    model_reset();
    rst = 1'b0;
    // Abandoned write left no trace; pointer restarted at "last served = B"
    qa.push_back(mk_acc(1'b0, 32'd5, 32'h0));
    qa.push_back(mk_acc(1'b0, 32'd6, 32'h0));
    qb.push_back(mk_acc(1'b0, 32'd7, 32'h0));
    run(15, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address port.
REQ-002 Parameter DATA_WIDTH, default 32, width of every data port.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_req / a_wren  input  1 each  CPU port: access request / write-enable.
REQ-006 a_addr  input  ADDR_WIDTH; a_wdata  input  DATA_WIDTH  CPU address and store data.
REQ-007 b_req / b_wren  input  1 each  loader/debug port: access request / write-enable.
REQ-008 b_addr  input  ADDR_WIDTH; b_wdata  input  DATA_WIDTH  loader address and store data.
REQ-009 a_gnt, b_gnt  output  1 each  one-cycle grant pulse to the winning port.
REQ-010 a_rvalid, b_rvalid  output  1 each  one-cycle completion pulse to the served port.
REQ-011 rdata  output  DATA_WIDTH  shared read data, valid while an rvalid is high.
REQ-012 mem_address  output  ADDR_WIDTH; mem_data  output  DATA_WIDTH; mem_wren  output  1  data-memory drive.
REQ-013 mem_q  input  DATA_WIDTH  data-memory read data, valid one cycle after the address edge.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, ISSUE, RESP.
REQ-016 IDLE: no req -> stay IDLE; any req -> choose winner, latch its addr/wdata/wren and port ID into holding registers, go to ISSUE.
REQ-017 ISSUE: drive mem_address/mem_data from holding registers, mem_wren = latched wren, pulse gnt of winner; go to RESP unconditionally.
REQ-018 RESP: mem_wren = 0; on the clock edge load rdata from mem_q (reads only) and set winner's rvalid for the next cycle; go to IDLE.
REQ-019 mem_wren SHALL be 1 only in ISSUE of a write; 0 in every other state.
REQ-020 Latency: req sampled in IDLE at cycle T -> gnt at T+1 -> rvalid and rdata at T+3; one access per 3 cycles max.
REQ-021 Writes SHALL also pulse rvalid at T+3; rdata SHALL then keep its previous value.
REQ-022 rvalid cycle coincides with IDLE; a new request SHALL be accepted in that same cycle.
REQ-023 Requesters SHALL hold req, addr, wdata, wren stable until gnt; req still high in IDLE after gnt is a new access.
REQ-024 Inputs SHALL be ignored in ISSUE and RESP; a_gnt and b_gnt SHALL never be high together.
REQ-025 Only one request -> that port wins regardless of priority mode.

Reset
REQ-026 rst high SHALL immediately force state IDLE and drive gnts, rvalids, mem_wren and busy to 0, independent of clk.
REQ-027 rdata, holding registers and mem_address/mem_data SHALL reset to 0; priority pointer SHALL reset to "last served = B".
REQ-028 Reset during ISSUE SHALL drop mem_wren before the next edge; that access is abandoned and no rvalid is produced.

Configuration
REQ-029 Macro DMEM_ARBITER_RR_EN defined: simultaneous requests go to the port not served last; pointer updates on every grant.
REQ-030 Macro undefined: fixed priority, port A always wins ties; no pointer register exists.

Verification
REQ-031 Single read: mem[0x10]=0xCAFE0001, a_req/a_addr=0x10 at T -> a_gnt at T+1, a_rvalid and rdata=0xCAFE0001 at T+3, busy high T+1..T+2.
REQ-032 Write then read: b write 0x20<-0x12345678 -> mem_wren=1 only in ISSUE, b_rvalid at T+3; following b read of 0x20 returns 0x12345678.
REQ-033 Tie, RR_EN defined: a_req and b_req held high from reset release -> grants alternate A,B,A,B every 3 cycles.
REQ-034 Tie, RR_EN undefined: both held high -> every grant goes to A; b_gnt never asserts.
REQ-035 Reset mid-op: rst asserted during ISSUE of an A write -> mem_wren falls in the same cycle, no a_rvalid, state IDLE, busy=0.
REQ-036 Back-to-back: a_req held through a_rvalid -> second a_gnt one cycle after first a_rvalid, no idle gap.
